// File: rtl/trace_sequencer.sv
// trace_sequencer
// Walks an execution trace through the combinational single-step verifier
// core. Each accepted step is registered onto core_step, the core gets one
// cycle to settle, and its predicted post-state is then compared with the
// register state carried by the next step of the trace.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse; begins or restarts a trace check
//   step_valid     trace step available on step_data/step_last
//   step_data      560-bit trace step (instr, 10 regs, two hint fields)
//   step_last      marks step_data as the final step of the trace
//   step_ready     sequencer accepts a step this cycle (registered)
//   core_step      registered step presented to the verifier core
//   core_regs      core post-state {eflags..eax}, eax at [31:0]
//   busy/done/pass check status; done is sticky until start/reset
//   fail_index     index of the step whose pre-state mismatched
//   fail_mask      per-register mismatch bits, CHECK_MASK order
//   steps_checked  transitions verified so far
module trace_sequencer #(
  parameter logic [9:0] CHECK_MASK = 10'h2FF,
  parameter int         CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_valid,
  input  logic [559:0]     step_data,
  input  logic             step_last,
  output logic             step_ready,
  output logic [559:0]     core_step,
  input  logic [319:0]     core_regs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_index,
  output logic [9:0]       fail_mask,
  output logic [CNT_W-1:0] steps_checked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_EXEC,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cur_idx;
  logic               last_q;
  logic [319:0]       expected;
  logic [9:0]         mism;
  logic               xfer;

  // step_ready is itself registered, so the transfer term has no
  // combinational dependence of ready on valid.
  assign xfer = step_valid && step_ready;

  // Register fields in step_data start at bit 96 and follow the same order
  // as core_regs, so field i of the step lines up with word i of expected.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 10; i++) begin
      mism[i] = CHECK_MASK[i] && (step_data[96 + 32*i +: 32] != expected[32*i +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      step_ready    <= 1'b0;
      core_step     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_index    <= '0;
      fail_mask     <= '0;
      steps_checked <= '0;
      cur_idx       <= '0;
      last_q        <= 1'b0;
      expected      <= '0;
    end else if (start) begin
      // start wins over any coincident transfer; core_step is left alone
      // because it is only meaningful once FIRST accepts a new step.
      state         <= S_FIRST;
      step_ready    <= 1'b1;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_index    <= '0;
      fail_mask     <= '0;
      steps_checked <= '0;
      cur_idx       <= '0;
      last_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          step_ready <= 1'b0;
        end
        S_FIRST: begin
          if (xfer) begin
            core_step  <= step_data;
            cur_idx    <= '0;
            last_q     <= step_last;
            step_ready <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The core is purely combinational from core_step; one cycle is
          // enough for it to settle before its prediction is captured.
          expected <= core_regs;
          if (last_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
            state <= S_DONE;
          end else begin
            step_ready <= 1'b1;
            state      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (xfer) begin
            step_ready <= 1'b0;
            if (mism != '0) begin
              fail_mask  <= mism;
              fail_index <= cur_idx + CNT_W'(1);
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= 1'b0;
              state      <= S_DONE;
            end else begin
              steps_checked <= steps_checked + CNT_W'(1);
              core_step     <= step_data;
              cur_idx       <= cur_idx + CNT_W'(1);
              last_q        <= step_last;
              state         <= S_EXEC;
            end
          end
        end
        S_DONE: begin
          step_ready <= 1'b0;
        end
        default: begin
          step_ready <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_sequencer.sv
// tb_trace_sequencer
// Drives two sequencers from one stimulus stream: one with the default
// compare mask (eip ignored) and one comparing all ten registers. The bench
// plays the verifier core (every register of the current step plus one), so
// a consistent trace has each register advancing by one per step.
module tb_trace_sequencer;

  localparam int         CNT_W = 32;
  localparam logic [9:0] MASK_DEF = 10'h2FF;
  localparam logic [9:0] MASK_ALL = 10'h3FF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             step_valid;
  logic [559:0]     step_data;
  logic             step_last;

  logic             dut_ready     [2];
  logic [559:0]     dut_core_step [2];
  logic [319:0]     dut_core_regs [2];
  logic             dut_busy      [2];
  logic             dut_done      [2];
  logic             dut_pass      [2];
  logic [CNT_W-1:0] dut_fail_idx  [2];
  logic [9:0]       dut_fail_mask [2];
  logic [CNT_W-1:0] dut_checked   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference core: predicted post-state is each pre-state register + 1.
  function automatic logic [319:0] core_model(input logic [559:0] s);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = s[96 + 32*i +: 32] + 32'd1;
    return r;
  endfunction

  // Step j of a consistent trace: register i holds base + 0x100*i + j.
  function automatic logic [559:0] mk_step(input int j, input logic [31:0] base);
    logic [559:0] s;
    logic [71:0]  h;
    s = '0;
    s[95:0] = {32'hC0DE0000 | 32'(j), 64'h0F1E_2D3C_4B5A_6978};
    for (int i = 0; i < 10; i++) s[96 + 32*i +: 32] = base + 32'h100 * i + 32'(j);
    h = 72'h11_2233_4455_6677_8899 ^ 72'(j);
    s[487:416] = h;
    s[559:488] = ~h;
    return s;
  endfunction

  // A step is consistent with its predecessor when every enabled register
  // equals the core's prediction from that predecessor.
  function automatic logic [9:0] pair_mism(input logic [559:0] prev, input logic [559:0] cur,
                                           input logic [9:0] mask);
    logic [319:0] p;
    logic [9:0]   m;
    p = core_model(prev);
    m = '0;
    for (int i = 0; i < 10; i++)
      if (mask[i] && (cur[96 + 32*i +: 32] != p[32*i +: 32])) m[i] = 1'b1;
    return m;
  endfunction

  assign dut_core_regs[0] = core_model(dut_core_step[0]);
  assign dut_core_regs[1] = core_model(dut_core_step[1]);

  trace_sequencer #(.CHECK_MASK(MASK_DEF), .CNT_W(CNT_W)) dut_def (
    .clk(clk), .rst_n(rst_n), .start(start), .step_valid(step_valid),
    .step_data(step_data), .step_last(step_last), .step_ready(dut_ready[0]),
    .core_step(dut_core_step[0]), .core_regs(dut_core_regs[0]), .busy(dut_busy[0]),
    .done(dut_done[0]), .pass(dut_pass[0]), .fail_index(dut_fail_idx[0]),
    .fail_mask(dut_fail_mask[0]), .steps_checked(dut_checked[0])
  );

  trace_sequencer #(.CHECK_MASK(MASK_ALL), .CNT_W(CNT_W)) dut_all (
    .clk(clk), .rst_n(rst_n), .start(start), .step_valid(step_valid),
    .step_data(step_data), .step_last(step_last), .step_ready(dut_ready[1]),
    .core_step(dut_core_step[1]), .core_regs(dut_core_regs[1]), .busy(dut_busy[1]),
    .done(dut_done[1]), .pass(dut_pass[1]), .fail_index(dut_fail_idx[1]),
    .fail_mask(dut_fail_mask[1]), .steps_checked(dut_checked[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: remembers the accepted trace and derives the
  // verdict from consecutive step pairs.
  bit               m_ready    [2];
  bit               m_settle   [2];
  bit               m_last     [2];
  bit               m_busy     [2];
  bit               m_done     [2];
  bit               m_pass     [2];
  logic [CNT_W-1:0] m_fail_idx [2];
  logic [9:0]       m_fail_mask[2];
  logic [CNT_W-1:0] m_checked  [2];
  logic [559:0]     m_core     [2];
  logic [559:0]     acc        [2][64];
  int               acc_n      [2];

  function automatic logic [9:0] mask_of(input int k);
    return (k == 0) ? MASK_DEF : MASK_ALL;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ready[k] <= 0; m_settle[k] <= 0; m_last[k] <= 0; m_busy[k] <= 0;
        m_done[k] <= 0; m_pass[k] <= 0; m_fail_idx[k] <= '0; m_fail_mask[k] <= '0;
        m_checked[k] <= '0; m_core[k] <= '0; acc_n[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (start) begin
          m_ready[k] <= 1; m_settle[k] <= 0; m_busy[k] <= 1; m_done[k] <= 0;
          m_pass[k] <= 0; m_fail_idx[k] <= '0; m_fail_mask[k] <= '0;
          m_checked[k] <= '0; acc_n[k] <= 0;
        end else if (m_settle[k]) begin
          m_settle[k] <= 0;
          if (m_last[k]) begin
            m_busy[k] <= 0; m_done[k] <= 1; m_pass[k] <= 1;
          end else begin
            m_ready[k] <= 1;
          end
        end else if (m_ready[k] && step_valid) begin
          m_ready[k] <= 0;
          if (acc_n[k] > 0 && pair_mism(acc[k][acc_n[k]-1], step_data, mask_of(k)) != '0) begin
            m_fail_mask[k] <= pair_mism(acc[k][acc_n[k]-1], step_data, mask_of(k));
            m_fail_idx[k]  <= CNT_W'(acc_n[k]);
            m_busy[k] <= 0; m_done[k] <= 1; m_pass[k] <= 0;
          end else begin
            if (acc_n[k] < 64) acc[k][acc_n[k]] <= step_data;
            acc_n[k]     <= acc_n[k] + 1;
            m_checked[k] <= CNT_W'(acc_n[k]);
            m_core[k]    <= step_data;
            m_last[k]    <= step_last;
            m_settle[k]  <= 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [559:0] act, input logic [559:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("d%0d_step_ready", k), 560'(dut_ready[k]), 560'(m_ready[k]));
      checkOutput($sformatf("d%0d_busy", k), 560'(dut_busy[k]), 560'(m_busy[k]));
      checkOutput($sformatf("d%0d_done", k), 560'(dut_done[k]), 560'(m_done[k]));
      checkOutput($sformatf("d%0d_pass", k), 560'(dut_pass[k]), 560'(m_pass[k]));
      checkOutput($sformatf("d%0d_fail_index", k), 560'(dut_fail_idx[k]), 560'(m_fail_idx[k]));
      checkOutput($sformatf("d%0d_fail_mask", k), 560'(dut_fail_mask[k]), 560'(m_fail_mask[k]));
      checkOutput($sformatf("d%0d_steps_checked", k), 560'(dut_checked[k]), 560'(m_checked[k]));
      checkOutput($sformatf("d%0d_core_step", k), dut_core_step[k], m_core[k]);
    end
  end

  // Offers one step, holding it until the default-mask sequencer takes it.
  task automatic applyStimulus(input logic [559:0] data, input bit last, input int stall_pct);
    bit got;
    int cyc;
    got = 0;
    cyc = 0;
    while (!got) begin
      step_valid = ($urandom_range(0, 99) >= stall_pct);
      step_data  = data;
      step_last  = last;
      @(negedge clk);
      got = step_valid && dut_ready[0];
      @(posedge clk);
      #1;
      cyc++;
      if (!got && cyc > 200) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL handshake_timeout: got no transfer, expected one within 200 cycles");
        got = 1;
      end
    end
    step_valid = 0;
  endtask

  task automatic pulseStart();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic waitDone();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!dut_done[0] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!dut_done[0]) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_timeout: got done=0, expected done=1 within 50 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [559:0] s;
    rst_n = 0; start = 0; step_valid = 0; step_data = '0; step_last = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 560'(dut_busy[0]), 560'(0));
    checkOutput("reset_ready", 560'(dut_ready[0]), 560'(0));
    checkOutput("reset_core_step", dut_core_step[0], '0);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Consistent three-step trace, last on step 2.
    $display("[TB] consistent trace");
    pulseStart();
    for (int j = 0; j < 3; j++) applyStimulus(mk_step(j, 32'h1000), (j == 2), 0);
    waitDone();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("t1_d%0d_pass", k), 560'(dut_pass[k]), 560'(1));
      checkOutput($sformatf("t1_d%0d_checked", k), 560'(dut_checked[k]), 560'(2));
      checkOutput($sformatf("t1_d%0d_fail_mask", k), 560'(dut_fail_mask[k]), 560'(0));
    end
    checkOutput("t1_model_checked", 560'(m_checked[0]), 560'(2));

    // Step 1 ebx off by one from the prediction.
    $display("[TB] ebx mismatch");
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(mk_step(0, 32'h2000), 0, 0);
    s = mk_step(1, 32'h2000);
    s[128 +: 32] = s[128 +: 32] + 32'd1;
    applyStimulus(s, 0, 0);
    waitDone();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("t2_d%0d_pass", k), 560'(dut_pass[k]), 560'(0));
      checkOutput($sformatf("t2_d%0d_fail_index", k), 560'(dut_fail_idx[k]), 560'(1));
      checkOutput($sformatf("t2_d%0d_fail_mask", k), 560'(dut_fail_mask[k]), 560'(10'h002));
      checkOutput($sformatf("t2_d%0d_checked", k), 560'(dut_checked[k]), 560'(0));
    end
    checkOutput("t2_model_mask", 560'(m_fail_mask[0]), 560'(10'h002));

    // Only eip wrong on step 1: ignored by default mask, caught by full mask.
    $display("[TB] eip-only mismatch");
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(mk_step(0, 32'h3000), 0, 0);
    s = mk_step(1, 32'h3000);
    s[352 +: 32] = s[352 +: 32] + 32'd5;
    applyStimulus(s, 0, 0);
    s = mk_step(2, 32'h3000);
    s[352 +: 32] = s[352 +: 32] + 32'd5;
    applyStimulus(s, 1, 0);
    waitDone();
    checkOutput("t3_def_pass", 560'(dut_pass[0]), 560'(1));
    checkOutput("t3_def_checked", 560'(dut_checked[0]), 560'(2));
    checkOutput("t3_all_pass", 560'(dut_pass[1]), 560'(0));
    checkOutput("t3_all_fail_mask", 560'(dut_fail_mask[1]), 560'(10'h100));
    checkOutput("t3_all_fail_index", 560'(dut_fail_idx[1]), 560'(1));

    // Stalled source: valid dropped randomly for about 40% of offers.
    $display("[TB] stalled source");
    @(posedge clk); #1;
    pulseStart();
    for (int j = 0; j < 5; j++) applyStimulus(mk_step(j, 32'h4000), (j == 4), 40);
    waitDone();
    checkOutput("t4_pass", 560'(dut_pass[0]), 560'(1));
    checkOutput("t4_checked", 560'(dut_checked[0]), 560'(4));
    checkOutput("t4_core_step", dut_core_step[0], mk_step(4, 32'h4000));

    // start while NEXT is offered a step: start wins, step not consumed.
    $display("[TB] restart during NEXT");
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(mk_step(0, 32'h5000), 0, 0);
    @(posedge clk); #1;
    start = 1; step_valid = 1; step_data = mk_step(1, 32'h5000); step_last = 0;
    @(posedge clk); #1;
    start = 0; step_valid = 0;
    @(negedge clk);
    checkOutput("t5_ready", 560'(dut_ready[0]), 560'(1));
    checkOutput("t5_checked", 560'(dut_checked[0]), 560'(0));
    checkOutput("t5_done", 560'(dut_done[0]), 560'(0));
    checkOutput("t5_busy", 560'(dut_busy[0]), 560'(1));
    checkOutput("t5_core_step", dut_core_step[0], mk_step(0, 32'h5000));
    @(posedge clk); #1;

    // Single-step trace straight after the restart.
    applyStimulus(mk_step(0, 32'h6000), 1, 0);
    waitDone();
    checkOutput("t6_pass", 560'(dut_pass[0]), 560'(1));
    checkOutput("t6_checked", 560'(dut_checked[0]), 560'(0));

    // Reset asserted mid-NEXT, away from any clock edge.
    $display("[TB] reset mid-NEXT");
    @(posedge clk); #1;
    pulseStart();
    applyStimulus(mk_step(0, 32'h7000), 0, 0);
    @(posedge clk); #3;
    step_valid = 1; step_data = mk_step(1, 32'h7000);
    rst_n = 0;
    #1;
    checkOutput("rst_ready", 560'(dut_ready[0]), 560'(0));
    checkOutput("rst_busy", 560'(dut_busy[0]), 560'(0));
    checkOutput("rst_done", 560'(dut_done[0]), 560'(0));
    checkOutput("rst_checked", 560'(dut_checked[0]), 560'(0));
    checkOutput("rst_core_step", dut_core_step[0], '0);
    @(posedge clk); #3;
    step_valid = 0;
    rst_n = 1;
    @(negedge clk);
    checkOutput("rst_ready_after", 560'(dut_ready[0]), 560'(0));
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
